// File: rtl/sclk_burst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sclk_burst_monitor
// Brief    : Oversamples a recovered serial-flash clock C on the system clock.
//            Rebuilds the burst-active window, measures every high/low phase
//            and period, counts rising edges per burst and flags short or
//            long phases with sticky error bits.
// Revision : 1.0 - initial release
// ============================================================================
module sclk_burst_monitor #(
  parameter int CNT_W    = 16,
  parameter int EDGE_W   = 32,
  parameter int MIN_HALF = 2,
  parameter int MAX_HALF = 1024,
  parameter int IDLE_TO  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_in,
  input  logic              clear,
  output logic              active,
  output logic              burst_start,
  output logic              burst_end,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  low_time,
  output logic [CNT_W:0]    period,
  output logic              meas_valid,
  output logic              err_short,
  output logic              err_long
);

  localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
  localparam logic [EDGE_W-1:0] C_EDGE_MAX = '1;
  localparam logic [CNT_W-1:0]  C_MIN_HALF = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0]  C_MAX_HALF = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0]  C_IDLE_TO  = CNT_W'(IDLE_TO);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_sync1;
  logic              r_c_s;
  logic              r_c_d;
  logic [CNT_W-1:0]  r_hcnt;
  logic [CNT_W-1:0]  r_lcnt;

  logic              w_rise;
  logic              w_fall;
  logic [CNT_W-1:0]  w_hcnt_inc;
  logic [CNT_W-1:0]  w_lcnt_inc;
  logic [EDGE_W-1:0] w_edge_inc;
  logic              w_short_det;
  logic              w_long_det;

  assign w_rise = r_c_s & ~r_c_d;
  assign w_fall = ~r_c_s & r_c_d;

  // Phase and edge counters saturate instead of wrapping so a stuck C never
  // looks like a short phase.
  assign w_hcnt_inc = (r_hcnt == C_CNT_MAX) ? r_hcnt : r_hcnt + CNT_W'(1);
  assign w_lcnt_inc = (r_lcnt == C_CNT_MAX) ? r_lcnt : r_lcnt + CNT_W'(1);
  assign w_edge_inc = (edge_cnt == C_EDGE_MAX) ? edge_cnt : edge_cnt + EDGE_W'(1);

  // Two-flop synchroniser for the asynchronous C, plus one delay stage for
  // edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_c_s   <= 1'b0;
      r_c_d   <= 1'b0;
    end else begin
      r_sync1 <= c_in;
      r_c_s   <= r_sync1;
      r_c_d   <= r_c_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and phase-violation detection.
  always_comb begin
    w_state_nxt = r_state;
    w_short_det = 1'b0;
    w_long_det  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        // A long high phase is only flagged; a stuck-high C keeps the burst open.
        if (r_hcnt > C_MAX_HALF) begin
          w_long_det = 1'b1;
        end
        if (w_fall) begin
          w_state_nxt = S_LOW;
          if (r_hcnt < C_MIN_HALF) begin
            w_short_det = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          if (r_lcnt < C_MIN_HALF) begin
            w_short_det = 1'b1;
          end
        end else if (r_lcnt == C_IDLE_TO) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst framing, phase counting and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      burst_start <= 1'b0;
      burst_end   <= 1'b0;
      meas_valid  <= 1'b0;
      edge_cnt    <= '0;
      high_time   <= '0;
      low_time    <= '0;
      period      <= '0;
      r_hcnt      <= '0;
      r_lcnt      <= '0;
    end else begin
      burst_start <= 1'b0;
      burst_end   <= 1'b0;
      meas_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            active      <= 1'b1;
            burst_start <= 1'b1;
            edge_cnt    <= EDGE_W'(1);
            r_hcnt      <= CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_fall) begin
            high_time <= r_hcnt;
            r_lcnt    <= CNT_W'(1);
          end else begin
            r_hcnt <= w_hcnt_inc;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            // A full cycle closes on the rise that ends its low phase.
            low_time   <= r_lcnt;
            period     <= {1'b0, high_time} + {1'b0, r_lcnt};
            meas_valid <= 1'b1;
            edge_cnt   <= w_edge_inc;
            r_hcnt     <= CNT_W'(1);
          end else if (r_lcnt == C_IDLE_TO) begin
            // The trailing low phase is idle time, not a clock phase, so the
            // measurement registers are left untouched.
            active    <= 1'b0;
            burst_end <= 1'b1;
          end else begin
            r_lcnt <= w_lcnt_inc;
          end
        end
        default: begin
          active <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a detection in the clear cycle takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= (err_short & ~clear) | w_short_det;
      err_long  <= (err_long  & ~clear) | w_long_det;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sclk_burst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sclk_burst_monitor
// Brief    : Self-checking bench for sclk_burst_monitor. A phase-length model
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sclk_burst_monitor;

  localparam int     CNT_W    = 16;
  localparam int     EDGE_W   = 32;
  localparam int     MIN_HALF = 2;
  localparam int     MAX_HALF = 1024;
  localparam int     IDLE_TO  = 4096;
  localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;
  localparam longint EDGE_MAX = (64'd1 << EDGE_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              c_in = 1'b0;
  logic              clear = 1'b0;
  logic              active;
  logic              burst_start;
  logic              burst_end;
  logic [EDGE_W-1:0] edge_cnt;
  logic [CNT_W-1:0]  high_time;
  logic [CNT_W-1:0]  low_time;
  logic [CNT_W:0]    period;
  logic              meas_valid;
  logic              err_short;
  logic              err_long;

  int checks   = 0;
  int failures = 0;
  int n_bs = 0;
  int n_be = 0;
  int n_mv = 0;

  sclk_burst_monitor #(
    .CNT_W(CNT_W), .EDGE_W(EDGE_W), .MIN_HALF(MIN_HALF),
    .MAX_HALF(MAX_HALF), .IDLE_TO(IDLE_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .c_in(c_in), .clear(clear),
    .active(active), .burst_start(burst_start), .burst_end(burst_end),
    .edge_cnt(edge_cnt), .high_time(high_time), .low_time(low_time),
    .period(period), .meas_valid(meas_valid),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (phase run lengths) ----------------
  // smp1..smp3: c_in as sampled 1, 2 and 3 edges ago; the monitor reacts to
  // the level seen two edges back.
  bit     smp1, smp2, smp3;
  longint run, prevrun;
  bit     in_burst;
  bit     e_active, e_bs, e_be, e_mv, e_es, e_el;
  longint e_edge, e_high, e_low, e_period;

  task automatic model_reset();
    smp1 = 0; smp2 = 0; smp3 = 0;
    run = 0; prevrun = 0; in_burst = 0;
    e_active = 0; e_bs = 0; e_be = 0; e_mv = 0; e_es = 0; e_el = 0;
    e_edge = 0; e_high = 0; e_low = 0; e_period = 0;
  endtask

  task automatic model_step(input bit cin, input bit clr);
    bit     cur, prev, det_s, det_l;
    longint len;
    cur = smp2; prev = smp3; det_s = 0; det_l = 0;
    e_bs = 0; e_be = 0; e_mv = 0;
    if (cur == prev) run++;
    else begin prevrun = run; run = 1; end
    if (!in_burst) begin
      if (cur && !prev) begin
        in_burst = 1; e_active = 1; e_bs = 1; e_edge = 1;
      end
    end else if (cur && !prev) begin
      len = (prevrun > CNT_MAX) ? CNT_MAX : prevrun;
      e_low = len; e_period = e_high + len; e_mv = 1;
      if (e_edge < EDGE_MAX) e_edge++;
      if (len < MIN_HALF) det_s = 1;
    end else if (!cur && prev) begin
      len = (prevrun > CNT_MAX) ? CNT_MAX : prevrun;
      e_high = len;
      if (len < MIN_HALF) det_s = 1;
      if (len > MAX_HALF) det_l = 1;
    end else if (cur && (run - 1) > MAX_HALF) begin
      det_l = 1;
    end else if (!cur && run == IDLE_TO + 1) begin
      in_burst = 0; e_active = 0; e_be = 1;
    end
    e_es = (e_es & !clr) | det_s;
    e_el = (e_el & !clr) | det_l;
    smp3 = smp2; smp2 = smp1; smp1 = cin;
  endtask

  // Per-cycle compare against the model, then advance it for the next edge.
  initial model_reset();
  always @(negedge clk) begin
    if (burst_start) n_bs++;
    if (burst_end)   n_be++;
    if (meas_valid)  n_mv++;
    if (!rst_n) begin
      chk("rst_active", active, 0);
      chk("rst_edge_cnt", edge_cnt, 0);
      chk("rst_period", period, 0);
      model_reset();
    end else begin
      chk("cyc_active", active, e_active);
      chk("cyc_burst_start", burst_start, e_bs);
      chk("cyc_burst_end", burst_end, e_be);
      chk("cyc_meas_valid", meas_valid, e_mv);
      chk("cyc_edge_cnt", edge_cnt, e_edge);
      chk("cyc_high_time", high_time, e_high);
      chk("cyc_low_time", low_time, e_low);
      chk("cyc_period", period, e_period);
      chk("cyc_err_short", err_short, e_es);
      chk("cyc_err_long", err_long, e_el);
      model_step(c_in, clear);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input int n);
    c_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    int bs0, be0, mv0, found;
    rst_n = 0; c_in = 0; clear = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    chk("reset_active", active, 0);
    chk("reset_edge_cnt", edge_cnt, 0);
    chk("reset_high_time", high_time, 0);
    chk("reset_err_short", err_short, 0);
    chk("reset_err_long", err_long, 0);

    // Test 1: four 5/5 cycles then long idle
    bs0 = n_bs; be0 = n_be; mv0 = n_mv;
    repeat (3) begin drive(1, 5); drive(0, 5); end
    drive(1, 5);
    c_in = 0; found = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (burst_end && found == 0) begin
        found = 1;
        chk("t1_end_delay", i, 4100);
      end
    end
    @(posedge clk); #1;
    chk("t1_end_seen", found, 1);
    chk("t1_starts", n_bs - bs0, 1);
    chk("t1_ends", n_be - be0, 1);
    chk("t1_meas", n_mv - mv0, 3);
    chk("t1_high", high_time, 5);
    chk("t1_low", low_time, 5);
    chk("t1_period", period, 10);
    chk("t1_edges", edge_cnt, 4);
    chk("t1_active", active, 0);
    chk("t1_err_short", err_short, 0);
    chk("t1_err_long", err_long, 0);

    // Test 2: one 1-clk high phase, sticky until clear
    drive(1, 5); drive(0, 5); drive(1, 1); drive(0, 5);
    drive(1, 5); drive(0, 5);
    chk("t2_err_short_set", err_short, 1);
    drive(0, 20);
    chk("t2_err_short_sticky", err_short, 1);
    pulse_clear();
    chk("t2_clear", err_short, 0);
    chk("t2_err_long", err_long, 0);
    drive(0, 4200);
    chk("t2_active_end", active, 0);

    // Test 3: C stuck high for 1100 clk
    be0 = n_be;
    drive(1, 1100);
    chk("t3_err_long", err_long, 1);
    chk("t3_active", active, 1);
    chk("t3_no_end", n_be - be0, 0);
    chk("t3_err_short", err_short, 0);
    drive(0, 4200);
    chk("t3_high_time", high_time, 1100);
    chk("t3_end", n_be - be0, 1);

    // Test 4: bursts of 3 and 7 edges
    pulse_clear();
    chk("t4_cleared_long", err_long, 0);
    bs0 = n_bs; be0 = n_be;
    repeat (3) begin drive(1, 4); drive(0, 4); end
    drive(0, 4992);
    chk("t4_edges_first", edge_cnt, 3);
    chk("t4_idle_between", active, 0);
    repeat (7) begin drive(1, 4); drive(0, 4); end
    drive(0, 4992);
    chk("t4_edges_second", edge_cnt, 7);
    chk("t4_starts", n_bs - bs0, 2);
    chk("t4_ends", n_be - be0, 2);

    // Test 5: reset mid-burst, released with C high
    be0 = n_be;
    repeat (3) begin drive(1, 3); drive(0, 3); end
    c_in = 1;
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("t5_async_active", active, 0);
    chk("t5_async_edge_cnt", edge_cnt, 0);
    chk("t5_async_high", high_time, 0);
    chk("t5_async_low", low_time, 0);
    @(posedge clk); #1;
    drive(0, 2); drive(1, 2);
    rst_n = 1; found = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (burst_start && found == 0) begin
        found = 1;
        chk("t5_restart_latency", i, 4);
        chk("t5_restart_edges", edge_cnt, 1);
        chk("t5_restart_active", active, 1);
      end
    end
    @(posedge clk); #1;
    chk("t5_restart_seen", found, 1);
    chk("t5_no_end_on_reset", n_be - be0, 0);
    drive(0, 3); drive(1, 3); drive(0, 4200);

    // Test 6: clear in the same clk as a short-phase detection
    pulse_clear();
    chk("t6_pre_clear", err_short, 0);
    drive(1, 5); drive(0, 5);
    c_in = 1; tick();
    c_in = 0; tick(); tick();
    clear = 1; tick(); clear = 0;
    drive(0, 3); drive(1, 5); drive(0, 5);
    chk("t6_detect_wins", err_short, 1);
    drive(0, 4200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
